// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender: mode encoding and its type.
package imm_ext_pkg;

  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_ZERO  = 2'b00;
  localparam ext_mode_t EXT_SIGN  = 2'b01;
  localparam ext_mode_t EXT_UPPER = 2'b10;
  localparam ext_mode_t EXT_RSVD  = 2'b11;

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational mode-to-result mapping for the immediate extender.
module imm_ext_comb
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] result,
  output logic             err
);

  // Slice assignments keep OUT_W == IN_W legal (no zero-width replication).
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (mode)
      EXT_ZERO: result[IN_W-1:0] = imm;
      EXT_SIGN: begin
        result            = {OUT_W{imm[IN_W-1]}};
        result[IN_W-1:0]  = imm;
      end
      EXT_UPPER: result[OUT_W-1 -: IN_W] = imm;
      EXT_RSVD:  err = 1'b1;
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: registered output plus one skid entry,
// valid/ready on both sides, synchronous flush.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  if (IN_W < 1 || OUT_W < IN_W) begin : g_bad_params
    $error("imm_ext_pipe: illegal widths IN_W=%0d OUT_W=%0d", IN_W, OUT_W);
  end

  logic [OUT_W-1:0] new_data;
  logic             new_err;
  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic             skid_err;
  logic             acc;
  logic             drain;

  imm_ext_comb #(.IN_W(IN_W), .OUT_W(OUT_W)) u_comb (
    .imm    (in_imm),
    .mode   (in_mode),
    .result (new_data),
    .err    (new_err)
  );

  // in_ready comes straight from the skid flop, so it carries no comb path.
  assign in_ready = ~skid_valid;
  assign acc      = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || drain) begin
      if (skid_valid) begin
        // Skid full means in_ready was low, so nothing new was accepted.
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_err    <= skid_err;
        skid_valid <= 1'b0;
      end else if (acc) begin
        out_valid <= 1'b1;
        out_data  <= new_data;
        out_err   <= new_err;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_data  <= new_data;
      skid_err   <= new_err;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: a 16->32 instance and an 8->8 instance.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_err;

  logic        in8_valid = 1'b0;
  logic        in8_ready;
  logic [7:0]  in8_imm = '0;
  logic [1:0]  in8_mode = 2'b00;
  logic        out8_valid;
  logic [7:0]  out8_data;
  logic        out8_err;

  int tests = 0;
  int failed = 0;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in8_valid), .in_ready(in8_ready), .in_imm(in8_imm), .in_mode(in8_mode),
    .out_valid(out8_valid), .out_ready(1'b1), .out_data(out8_data), .out_err(out8_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready", in_ready, 1);
    #10 rst_n = 1'b1;
    step();

    // 1: ZERO/SIGN/UPPER back-to-back
    out_ready = 1'b1;
    in_valid = 1'b1; in_imm = 16'h8001; in_mode = 2'b00;
    step();
    chk("t1_zero_valid", out_valid, 1);
    chk("t1_zero_data", out_data, 32'h0000_8001);
    chk("t1_zero_err", out_err, 0);
    chk("t1_ready_a", in_ready, 1);
    in_mode = 2'b01;
    step();
    chk("t1_sign_data", out_data, 32'hFFFF_8001);
    chk("t1_ready_b", in_ready, 1);
    in_mode = 2'b10;
    step();
    chk("t1_upper_data", out_data, 32'h8001_0000);
    chk("t1_upper_err", out_err, 0);

    // 2: reserved mode then a normal SIGN
    in_imm = 16'h1234; in_mode = 2'b11;
    step();
    chk("t2_rsvd_data", out_data, 0);
    chk("t2_rsvd_err", out_err, 1);
    in_imm = 16'h7FFF; in_mode = 2'b01;
    step();
    chk("t2_sign_data", out_data, 32'h0000_7FFF);
    chk("t2_sign_err", out_err, 0);
    in_valid = 1'b0;
    step();
    chk("t2_idle_valid", out_valid, 0);

    // 3: backpressure fills output + skid, then drains in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b00; in_imm = 16'h0001;
    step();
    chk("t3_first_data", out_data, 32'h1);
    chk("t3_ready_after1", in_ready, 1);
    in_imm = 16'h0002;
    step();
    chk("t3_ready_after2", in_ready, 0);
    in_imm = 16'h0003;
    step();
    chk("t3_hold_data", out_data, 32'h1);
    chk("t3_hold_valid", out_valid, 1);
    chk("t3_third_blocked", in_ready, 0);
    step();
    chk("t3_hold_data2", out_data, 32'h1);
    out_ready = 1'b1;
    step();
    chk("t3_drain2_valid", out_valid, 1);
    chk("t3_drain2_data", out_data, 32'h2);
    chk("t3_drain2_ready", in_ready, 1);
    step();
    chk("t3_drain3_valid", out_valid, 1);
    chk("t3_drain3_data", out_data, 32'h3);
    in_valid = 1'b0;
    step();
    chk("t3_empty", out_valid, 0);

    // 4: eight back-to-back transfers at full rate
    in_valid = 1'b1; in_mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      in_imm = 16'hFFF0 + 16'(i);
      step();
      chk("t4_valid", out_valid, 1);
      chk("t4_data", out_data, 32'hFFFF_FFF0 + 32'(i));
      chk("t4_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("t4_empty", out_valid, 0);

    // 5: flush with skid full and a concurrent input
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b00; in_imm = 16'h00AA;
    step();
    in_imm = 16'h00BB;
    step();
    chk("t5_full", in_ready, 0);
    flush = 1'b1; in_imm = 16'h00CC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_flush_valid", out_valid, 0);
    chk("t5_flush_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("t5_nothing_a", out_valid, 0);
    step();
    chk("t5_nothing_b", out_valid, 0);

    // 6: async reset with both entries full
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0011;
    step();
    in_imm = 16'h0022;
    step();
    in_valid = 1'b0;
    chk("t6_full_ready", in_ready, 0);
    chk("t6_full_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_ready", in_ready, 1);
    #1 rst_n = 1'b1;
    step();
    chk("t6_after_rst_valid", out_valid, 0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 2'b00; in_imm = 16'h0055;
    step();
    chk("t6_first_valid", out_valid, 1);
    chk("t6_first_data", out_data, 32'h55);
    in_valid = 1'b0;

    // 6b: IN_W == OUT_W instance
    in8_valid = 1'b1; in8_mode = 2'b01; in8_imm = 8'h80;
    step();
    chk("t6b_sign_valid", out8_valid, 1);
    chk("t6b_sign_data", out8_data, 8'h80);
    chk("t6b_sign_err", out8_err, 0);
    in8_mode = 2'b10; in8_imm = 8'h5A;
    step();
    chk("t6b_upper_data", out8_data, 8'h5A);
    in8_mode = 2'b00; in8_imm = 8'hC3;
    step();
    chk("t6b_zero_data", out8_data, 8'hC3);
    in8_mode = 2'b11; in8_imm = 8'h77;
    step();
    chk("t6b_rsvd_data", out8_data, 8'h00);
    chk("t6b_rsvd_err", out8_err, 1);
    in8_valid = 1'b0;
    step();
    chk("t6b_empty", out8_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
